// File: rtl/lock_pkg.sv
// Shared encodings and default code for the key-sequence lock.
package lock_pkg;

    localparam int unsigned DEF_KW       = 2;
    localparam int unsigned DEF_CODE_LEN = 4;
    localparam logic [DEF_KW*DEF_CODE_LEN-1:0] DEF_CODE = 8'hE4;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        ENTRY   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Largest of three cycle counts, used to size the shared timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable saturating down-counter with a registered zero flag.
module lock_timer #(
    parameter int unsigned TW = 6
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] count;
    logic [TW-1:0] count_next_c;

    // Next count: load wins, otherwise decrement until zero.
    always_comb begin
        count_next_c = count;
        if (load) begin
            count_next_c = load_val;
        end else if (count != '0) begin
            count_next_c = count - TW'(1);
        end
    end

    // Count register and zero flag tracking it.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            count <= '0;
            zero  <= 1'b1;
        end else begin
            count <= count_next_c;
            zero  <= (count_next_c == '0);
        end
    end

endmodule

// File: rtl/lock_seq_checker.sv
// Collects a key-pulse sequence, compares it to CODE, and drives open/error/lockout.
module lock_seq_checker
    import lock_pkg::*;
#(
    parameter int unsigned NKEYS       = 4,
    parameter int unsigned KW          = DEF_KW,
    parameter int unsigned CODE_LEN    = DEF_CODE_LEN,
    parameter logic [KW*CODE_LEN-1:0] CODE = DEF_CODE,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned OPEN_CYCLES = 8,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic                              Clock,
    input  logic                              Resetn,
    input  logic [NKEYS-1:0]                  key_pulse,
    input  logic                              relock,
    output logic                              unlocked,
    output logic                              error,
    output logic                              locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_count
);

    localparam int unsigned DCW  = $clog2(CODE_LEN + 1);
    localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMAX = max3(OPEN_CYCLES, LOCK_CYCLES, TIMEOUT);
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_t        state;
    logic          match;
    logic [FW-1:0] fail_cnt;

    logic          press_c;
    logic          single_c;
    logic [KW-1:0] key_idx_c;
    logic [KW-1:0] code_digit_c;
    logic          match_next_c;
    logic          last_c;
    logic          fail_hit_c;
    logic          tmr_load_c;
    logic [TW-1:0] tmr_val_c;
    logic          tmr_zero;

    lock_timer #(.TW(TW)) u_timer (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .zero     (tmr_zero)
    );

    // Digit compare, end-of-entry detect and timer reload on every state entry.
    always_comb begin
        press_c   = |key_pulse;
        single_c  = $onehot(key_pulse);
        key_idx_c = '0;
        for (int k = 0; k < int'(NKEYS); k++) begin
            if (key_pulse[k]) key_idx_c = KW'(k);
        end
        code_digit_c = (state == ENTRY) ? CODE[int'(digit_count)*int'(KW) +: KW]
                                        : CODE[KW-1:0];
        // A multi-key press can never match but still takes a digit slot.
        match_next_c = ((state == ENTRY) ? match : 1'b1) && single_c &&
                       (key_idx_c == code_digit_c);
        last_c = press_c &&
                 (((state == LOCKED) && (CODE_LEN == 1)) ||
                  ((state == ENTRY) && (digit_count == DCW'(CODE_LEN - 1))));
        fail_hit_c = (fail_cnt == FW'(MAX_FAIL - 1));

        tmr_load_c = 1'b0;
        tmr_val_c  = TW'(TIMEOUT - 1);
        if (last_c) begin
            if (match_next_c) begin
                tmr_load_c = 1'b1;
                tmr_val_c  = TW'(OPEN_CYCLES - 1);
            end else if (fail_hit_c) begin
                tmr_load_c = 1'b1;
                tmr_val_c  = TW'(LOCK_CYCLES - 1);
            end
        end else if (press_c && ((state == LOCKED) || (state == ENTRY))) begin
            tmr_load_c = 1'b1;
        end
    end

    // Lock FSM with registered outputs and fail counter.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= LOCKED;
            match       <= 1'b0;
            fail_cnt    <= '0;
            digit_count <= '0;
            unlocked    <= 1'b0;
            error       <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            error <= 1'b0;
            if (last_c) begin
                digit_count <= '0;
                match       <= 1'b0;
                if (match_next_c) begin
                    state    <= OPEN;
                    unlocked <= 1'b1;
                    fail_cnt <= '0;
                end else begin
                    error    <= 1'b1;
                    fail_cnt <= fail_cnt + FW'(1);
                    if (fail_hit_c) begin
                        state      <= LOCKOUT;
                        locked_out <= 1'b1;
                    end else begin
                        state <= LOCKED;
                    end
                end
            end else begin
                case (state)
                    LOCKED: begin
                        if (press_c) begin
                            state       <= ENTRY;
                            digit_count <= DCW'(1);
                            match       <= match_next_c;
                        end
                    end
                    ENTRY: begin
                        if (press_c) begin
                            digit_count <= digit_count + DCW'(1);
                            match       <= match_next_c;
                        end else if (tmr_zero) begin
                            state       <= LOCKED;
                            digit_count <= '0;
                            match       <= 1'b0;
                        end
                    end
                    OPEN: begin
                        if (relock || tmr_zero) begin
                            state    <= LOCKED;
                            unlocked <= 1'b0;
                        end
                    end
                    LOCKOUT: begin
                        if (tmr_zero) begin
                            state      <= LOCKED;
                            locked_out <= 1'b0;
                            fail_cnt   <= '0;
                        end
                    end
                    default: begin
                        state       <= LOCKED;
                        match       <= 1'b0;
                        fail_cnt    <= '0;
                        digit_count <= '0;
                        unlocked    <= 1'b0;
                        locked_out  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
